// File: rtl/stopwatch_scan_display.sv
// MM:SS stopwatch driven by a sampled 1 Hz strobe, scanned onto a common-anode 4-digit display.
// Define STOPWATCH_LAP_EN to add the lap-freeze snapshot on btn_lap.
module stopwatch_scan_display #(
    parameter int MIN_LIMIT = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_1hz,
    input  logic [1:0] clk_ctl,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [3:0] ssd_ctl,
    output logic [7:0] segs,
    output logic       running
);

`ifdef STOPWATCH_LAP_EN
    localparam int NSYNC = 4;
`else
    localparam int NSYNC = 3;
`endif

    localparam logic [3:0] LIM_M1 = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] LIM_M0 = 4'(MIN_LIMIT % 10);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    logic [NSYNC-1:0] raw_in;
    logic [NSYNC-1:0] pulse;
    logic             tick, start_p, clear_p;

`ifdef STOPWATCH_LAP_EN
    assign raw_in = {btn_lap, btn_clear, btn_start_stop, clk_1hz};
`else
    assign raw_in = {btn_clear, btn_start_stop, clk_1hz};
`endif

    // Two sync flops, a delay flop for edge detection, then a registered rising-edge pulse.
    for (genvar gi = 0; gi < NSYNC; gi++) begin : g_sync
        logic meta_q, sync_q, prev_q, pulse_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_q  <= 1'b0;
                sync_q  <= 1'b0;
                prev_q  <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                meta_q  <= raw_in[gi];
                sync_q  <= meta_q;
                prev_q  <= sync_q;
                pulse_q <= sync_q & ~prev_q;
            end
        end
        assign pulse[gi] = pulse_q;
    end

    assign tick    = pulse[0];
    assign start_p = pulse[1];
    assign clear_p = pulse[2];

    state_t state_q;
    logic   running_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else if (clear_p) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else if (start_p) begin
            case (state_q)
                RUN: begin
                    state_q   <= PAUSE;
                    running_q <= 1'b0;
                end
                IDLE, PAUSE: begin
                    state_q   <= RUN;
                    running_q <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    // Packed BCD time: {m1, m0, s1, s0}.
    logic [15:0] time_q, time_d, time_inc;

    always_comb begin
        time_inc = time_q;
        if (time_q[3:0] != 4'd9) begin
            time_inc[3:0] = time_q[3:0] + 4'd1;
        end else begin
            time_inc[3:0] = 4'd0;
            if (time_q[7:4] != 4'd5) begin
                time_inc[7:4] = time_q[7:4] + 4'd1;
            end else begin
                time_inc[7:4] = 4'd0;
                if (time_q[15:8] == {LIM_M1, LIM_M0}) begin
                    time_inc[15:8] = 8'd0;
                end else if (time_q[11:8] != 4'd9) begin
                    time_inc[11:8] = time_q[11:8] + 4'd1;
                end else begin
                    time_inc[11:8]  = 4'd0;
                    time_inc[15:12] = time_q[15:12] + 4'd1;
                end
            end
        end
    end

    // The tick is judged against the pre-transition state, so RUN->PAUSE still counts it.
    always_comb begin
        time_d = time_q;
        if (clear_p) begin
            time_d = 16'd0;
        end else if (tick && state_q == RUN) begin
            time_d = time_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q <= 16'd0;
        end else begin
            time_q <= time_d;
        end
    end

    logic [15:0] disp_time;

`ifdef STOPWATCH_LAP_EN
    logic        lap_p;
    logic        frozen_q;
    logic [15:0] snap_q;

    assign lap_p = pulse[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frozen_q <= 1'b0;
            snap_q   <= 16'd0;
        end else if (clear_p) begin
            frozen_q <= 1'b0;
        end else if (lap_p && state_q == RUN) begin
            frozen_q <= ~frozen_q;
            if (!frozen_q) begin
                snap_q <= time_q;
            end
        end
    end

    assign disp_time = frozen_q ? snap_q : time_q;
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign disp_time  = time_q;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [3:0] digit_sel;

    always_comb begin
        case (clk_ctl)
            2'b00:   digit_sel = disp_time[3:0];
            2'b01:   digit_sel = disp_time[7:4];
            2'b10:   digit_sel = disp_time[11:8];
            default: digit_sel = disp_time[15:12];
        endcase
    end

    logic [3:0] ssd_ctl_q;
    logic [7:0] segs_q;

    // dp (active low) doubles as the colon beside the minutes-ones digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssd_ctl_q <= 4'b1111;
            segs_q    <= 8'hFF;
        end else begin
            ssd_ctl_q <= ~(4'b0001 << clk_ctl);
            segs_q    <= {seg7(digit_sel), clk_ctl != 2'b10};
        end
    end

    assign ssd_ctl = ssd_ctl_q;
    assign segs    = segs_q;
    assign running = running_q;

endmodule
